cond_logic_mc: RTL and testbench

//  Conditional-execution unit for the multicycle ARM datapath; consumes the decoder's

---
 rtl/cond_logic_mc.sv | 97 +++++++++
 tb/tb_cond_logic_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic_mc.sv
// Conditional-execution unit for the multicycle ARM datapath: holds NZCV, evaluates
// the condition field, gates write requests and keeps saturating fetch/squash counters.
module cond_logic_mc #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondEx,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic n, z, c, v;
    logic cond_ex_reg;
    logic squash_pend;
    logic blocked;
    logic squash_now;

    assign {n, z, c, v} = Flags;

    always_comb begin
        case (Cond)
            4'h0:    CondEx = z;
            4'h1:    CondEx = ~z;
            4'h2:    CondEx = c;
            4'h3:    CondEx = ~c;
            4'h4:    CondEx = n;
            4'h5:    CondEx = ~n;
            4'h6:    CondEx = v;
            4'h7:    CondEx = ~v;
            4'h8:    CondEx = c & ~z;
            4'h9:    CondEx = ~c | z;
            4'hA:    CondEx = (n == v);
            4'hB:    CondEx = (n != v);
            4'hC:    CondEx = ~z & (n == v);
            4'hD:    CondEx = z | (n != v);
            4'hE:    CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    // Write-back strobes use the condition latched a cycle earlier, so a flag
    // update made in the execute cycle cannot retroactively cancel them.
    assign PCWrite  = NextPC | (PCS & cond_ex_reg);
    assign RegWrite = RegW & cond_ex_reg & ~NoWrite;
    assign MemWrite = MemW & cond_ex_reg;

    assign blocked = (|FlagW & ~CondEx)
                   | (RegW & ~NoWrite & ~cond_ex_reg)
                   | (MemW & ~cond_ex_reg)
                   | (PCS & ~cond_ex_reg);

    assign squash_now = squash_pend | blocked;

    // NOTE: state uses non-blocking assignments and an async reset; the N,Z and
    // C,V halves are written independently so neither disturbs the other.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags       <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            cond_ex_reg <= CondEx;
            if (FlagW[1] && CondEx) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] && CondEx) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // A blocked request in the NextPC cycle is charged to the instruction that is closing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            squash_pend <= 1'b0;
            fetch_cnt   <= '0;
            squash_cnt  <= '0;
        end else if (NextPC) begin
            squash_pend <= 1'b0;
            if (fetch_cnt != CNT_MAX) fetch_cnt <= fetch_cnt + 1'b1;
            if (squash_now && (squash_cnt != CNT_MAX)) squash_cnt <= squash_cnt + 1'b1;
        end else begin
            squash_pend <= squash_now;
        end
    end

endmodule

// File: tb/tb_cond_logic_mc.sv
// Scoreboard bench for cond_logic_mc: a behavioural model pushes expected outputs per
// stimulus and they are popped and compared once the DUT outputs have settled.
module tb_cond_logic_mc;

    logic        clk;
    logic        reset;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, NextPC, RegW, MemW, NoWrite;

    logic        PCWrite, RegWrite, MemWrite, CondEx;
    logic [3:0]  Flags;
    logic [31:0] fetch_cnt, squash_cnt;

    logic        s_pc, s_rw, s_mw, s_ce;
    logic [3:0]  s_flags;
    logic [1:0]  s_fetch, s_squash;

    cond_logic_mc #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
        .CondEx(CondEx), .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
    );

    cond_logic_mc #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCWrite(s_pc), .RegWrite(s_rw), .MemWrite(s_mw), .Flags(s_flags),
        .CondEx(s_ce), .fetch_cnt(s_fetch), .squash_cnt(s_squash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce, pc, rw, mw;
        logic [3:0]  flags;
        logic [31:0] fetch, squash;
        logic [1:0]  fetch2, squash2;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0]  m_flags;
    logic        m_cer, m_pend;
    logic [31:0] m_fetch, m_squash;
    logic [1:0]  m_fetch2, m_squash2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cc)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return !(fn ^ fv);
            4'd11: return fn ^ fv;
            4'd12: return !fz && !(fn ^ fv);
            4'd13: return fz || (fn ^ fv);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 4'b0; m_cer = 1'b0; m_pend = 1'b0;
        m_fetch = 0; m_squash = 0; m_fetch2 = 2'd0; m_squash2 = 2'd0;
    endtask

    task automatic model_update();
        logic ce, blk;
        ce  = cond_model(Cond, m_flags);
        blk = ((FlagW != 2'b00) && !ce) || (RegW && !NoWrite && !m_cer)
            || (MemW && !m_cer) || (PCS && !m_cer);
        if (FlagW[1] && ce) m_flags[3:2] = ALUFlags[3:2];
        if (FlagW[0] && ce) m_flags[1:0] = ALUFlags[1:0];
        m_cer = ce;
        if (NextPC) begin
            if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
            if (m_fetch2 != 2'd3) m_fetch2++;
            if (m_pend || blk) begin
                if (m_squash != 32'hFFFF_FFFF) m_squash++;
                if (m_squash2 != 2'd3) m_squash2++;
            end
            m_pend = 1'b0;
        end else begin
            m_pend = m_pend || blk;
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("cond_ex",   {31'd0, CondEx},   {31'd0, e.ce});
            check("pc_write",  {31'd0, PCWrite},  {31'd0, e.pc});
            check("reg_write", {31'd0, RegWrite}, {31'd0, e.rw});
            check("mem_write", {31'd0, MemWrite}, {31'd0, e.mw});
            check("flags",     {28'd0, Flags},    {28'd0, e.flags});
            check("fetch_cnt", fetch_cnt,         e.fetch);
            check("squash_cnt", squash_cnt,       e.squash);
            check("fetch_sat", {30'd0, s_fetch},  {30'd0, e.fetch2});
            check("squash_sat", {30'd0, s_squash}, {30'd0, e.squash2});
        end
    endtask

    task automatic drive(input logic [3:0] cc, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic npc, input logic rw,
                         input logic mw, input logic nw);
        exp_t e;
        Cond = cc; ALUFlags = alu; FlagW = fw;
        PCS = pcs; NextPC = npc; RegW = rw; MemW = mw; NoWrite = nw;
        e.ce      = cond_model(cc, m_flags);
        e.pc      = npc || (pcs && m_cer);
        e.rw      = rw && m_cer && !nw;
        e.mw      = mw && m_cer;
        e.flags   = m_flags;
        e.fetch   = m_fetch;
        e.squash  = m_squash;
        e.fetch2  = m_fetch2;
        e.squash2 = m_squash2;
        sb.push_back(e);
        #1;
        compare_out();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_update();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic cyc(input logic [3:0] cc, input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic npc, input logic rw,
                       input logic mw, input logic nw);
        drive(cc, alu, fw, pcs, npc, rw, mw, nw);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 0; NextPC = 0; RegW = 0; MemW = 0; NoWrite = 0;
        model_reset();
        @(negedge clk);

        // Reset held: random activity must not move any state
        for (int i = 0; i < 4; i++)
            cyc(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
        check("rst_flags", {28'd0, Flags}, 32'd0);
        check("rst_fetch", fetch_cnt, 32'd0);

        reset = 1'b1;
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 0);   // CondExReg still 0
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 0);   // now RegWrite=1

        // Independent flag halves
        cyc(4'hE, 4'b0111, 2'b10, 0, 0, 0, 0, 0);
        drive(4'hE, 4'b1011, 2'b01, 0, 0, 0, 0, 0);
        check("flags_nz_only", {28'd0, Flags}, 32'h4);
        tick();
        drive(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        check("flags_cv_only", {28'd0, Flags}, 32'h7);
        tick();

        // Full condition sweep
        for (int f = 0; f < 16; f++) begin
            cyc(4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0);
            for (int cc = 0; cc < 16; cc++)
                drive(4'(cc), 4'h0, 2'b00, 0, 0, 0, 0, 0);
            if (f == 9) begin
                Cond = 4'hC; #1;
                check("gt_nv_set", {31'd0, CondEx}, 32'd1);
            end
        end

        // Gating with a failing EQ (Z=0)
        cyc(4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 0);
        cyc(4'h0, 4'h0, 2'b00, 1, 0, 1, 1, 0);
        cyc(4'h0, 4'h0, 2'b00, 1, 0, 1, 1, 0);
        cyc(4'h0, 4'h0, 2'b00, 1, 1, 1, 1, 0);
        // NoWrite with AL
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 1);
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 1);

        // Compare sets Z in execute; following EQ writeback must see it
        cyc(4'hE, 4'b0100, 2'b10, 0, 0, 0, 0, 0);
        cyc(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0);
        cyc(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        drive(4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0);
        check("stale_eq_rw", {31'd0, RegWrite}, 32'd1);
        tick();

        // Counter scenario from a fresh reset (flags clear, so EQ fails)
        reset = 1'b0; model_reset(); #1; reset = 1'b1;
        cyc(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0);    // I1
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 0);
        cyc(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0);    // I2, fails
        cyc(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        cyc(4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0);
        cyc(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0);    // I3
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 0);
        cyc(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0);    // I4, fails
        cyc(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        cyc(4'h0, 4'h0, 2'b00, 1, 1, 0, 0, 0);    // I5 fetch + I4 blocked PCS
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 0);
        drive(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        check("cnt_fetch5", fetch_cnt, 32'd5);
        check("cnt_squash2", squash_cnt, 32'd2);
        tick();
        cyc(4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0);    // sixth fetch
        drive(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        check("sat_fetch6", {30'd0, s_fetch}, 32'd3);
        tick();

        // Asynchronous reset between edges
        cyc(4'hE, 4'hF, 2'b11, 0, 1, 0, 0, 0);
        #2;
        reset = 1'b0; model_reset();
        drive(4'hE, 4'hF, 2'b11, 1, 0, 1, 1, 0);
        check("async_flags", {28'd0, Flags}, 32'd0);
        tick();
        reset = 1'b1;
        cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        drive(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
